// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset sequencer: lw 5, sw/R/addi 4, branch/jump 3 cycles at zero-wait memory.
// Memory states stall on mem_ready=0 (one cycle each); a stall run of TIMEOUT_CYCLES traps.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       reg_ra,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t        cur_state, nxt_state;
  logic [CW-1:0] wait_q, wait_d;
  logic [1:0]    cause_q, cause_d;
  logic          mem_state;
  logic          timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
      wait_q    <= '0;
      cause_q   <= 2'b00;
    end else begin
      cur_state <= nxt_state;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
    end
  end

  // wait_q holds stall cycles already spent, so the current stalled cycle is wait_q+1
  always_comb begin
    mem_state = (cur_state == S_FETCH) || (cur_state == S_MEMREAD) || (cur_state == S_MEMWRITE);
    timeout   = (TIMEOUT_CYCLES != 0) && mem_state && !mem_ready &&
                (wait_q == CW'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    nxt_state = cur_state;
    cause_d   = cause_q;
    case (cur_state)
      S_FETCH:    if (mem_ready) nxt_state = S_DECODE;
      S_DECODE: begin
        casez (op)
          6'b000000:           nxt_state = S_EXECUTE;
          6'b100011, 6'b101011: nxt_state = S_MEMADR;
          6'b00010?:           nxt_state = S_BRANCH;
          6'b00100?:           nxt_state = S_ADDIEX;
          6'b000010:           nxt_state = S_JUMP;
          6'b000011:           nxt_state = S_JAL;
          default: begin
            nxt_state = S_TRAP;
            cause_d   = 2'b01;
          end
        endcase
      end
      S_MEMADR:   nxt_state = (op == 6'b101011) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) nxt_state = S_MEMWB;
      S_MEMWB:    nxt_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) nxt_state = S_FETCH;
      S_EXECUTE:  nxt_state = S_ALUWB;
      S_ALUWB:    nxt_state = S_FETCH;
      S_BRANCH:   nxt_state = S_FETCH;
      S_ADDIEX:   nxt_state = S_ADDIWB;
      S_ADDIWB:   nxt_state = S_FETCH;
      S_JUMP:     nxt_state = S_FETCH;
      S_JAL:      nxt_state = S_FETCH;
      default:    nxt_state = S_TRAP;
    endcase
    if (timeout) begin
      nxt_state = S_TRAP;
      cause_d   = 2'b10;
    end
  end

  // Stall counter saturates so a disabled timeout never wraps into a false match
  always_comb begin
    wait_d = '0;
    if (mem_state && !mem_ready && (nxt_state == cur_state))
      wait_d = (wait_q == {CW{1'b1}}) ? wait_q : wait_q + 1'b1;
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    reg_ra     = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    retire     = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        alu_src_b = (funct == 6'b000000) ? 2'b10 : 2'b00;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero ^ op[0];
        retire    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_en  = 1'b1;
        pc_src = 2'b10;
        retire = 1'b1;
      end
      S_JAL: begin
        pc_en     = 1'b1;
        pc_src    = 2'b10;
        reg_write = 1'b1;
        reg_ra    = 1'b1;
        pc_to_reg = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
    // Reset already parks state in FETCH; this also kills FETCH's request and handshake enables
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

  assign trap       = (cur_state == S_TRAP);
  assign trap_cause = cause_q;
  assign state      = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench: per-instruction expected cycle tables with random waits, zero and opcodes.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b, alu_op, trap_cause;
  logic       alu_src_a, reg_write, reg_dst, reg_ra, mem_to_reg, pc_to_reg, retire, trap;
  logic [3:0] state;

  multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .reg_ra(reg_ra),
    .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg), .retire(retire), .trap(trap),
    .trap_cause(trap_cause), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mr, mw, iord, irw, pce;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb, aop;
    logic       rw, rd, ra, m2r, p2r, ret, trap;
    logic [1:0] cause;
  } ctl_t;

  typedef struct {
    ctl_t  e;
    logic  rdy;
    logic  z;
    string tag;
  } step_t;

  ctl_t got;
  assign got = {state, mem_read, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_write, reg_dst, reg_ra, mem_to_reg, pc_to_reg,
                retire, trap, trap_cause};

  step_t      q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [5:0] op_v, funct_v;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic ctl_t mk(int st);
    ctl_t c;
    c = '0;
    c.st = 4'(st);
    return c;
  endfunction

  task automatic check(string tag, ctl_t exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(ctl_t e, logic rdy, logic z, string tag);
    step_t s;
    s.e = e; s.rdy = rdy; s.z = z; s.tag = tag;
    q.push_back(s);
  endtask

  // Entered and left at posedge+1; each step is one clock, checked at the falling edge
  task automatic run_q();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      op = op_v; funct = funct_v; zero = s.z; mem_ready = s.rdy;
      @(negedge clk);
      check(s.tag, s.e);
      @(posedge clk); #1;
    end
  endtask

  task automatic push_trap(logic [1:0] cause, int n);
    ctl_t c;
    c = mk(13); c.trap = 1'b1; c.cause = cause;
    for (int i = 0; i < n; i++) push(c, rb(), rb(), "trap_hold");
  endtask

  // w stall cycles, then completion; four stalls exhaust the timeout of 4
  task automatic plan_wait(ctl_t cw, ctl_t cd, int w, string tag, output bit tr);
    tr = (w >= 4);
    for (int i = 0; i < (tr ? 4 : w); i++) push(cw, 1'b0, rb(), {tag, "_wait"});
    if (tr) push_trap(2'b10, 3);
    else push(cd, 1'b1, rb(), tag);
  endtask

  task automatic do_reset(string tag);
    ctl_t r;
    r = mk(0); r.asb = 2'b01;
    mem_ready = 1'b1;
    reset = 1'b1;
    #1 check({tag, "_async"}, r);
    @(negedge clk);
    check({tag, "_hold"}, r);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // kind: 0 R, 1 lw, 2 sw, 3 beq, 4 bne, 5 addi, 6 addiu, 7 j, 8 jal, 9 illegal
  task automatic do_instr(int kind, int wf, int wm, logic z);
    ctl_t c, d;
    bit tr;
    case (kind)
      0: op_v = 6'b000000;  1: op_v = 6'b100011;  2: op_v = 6'b101011;
      3: op_v = 6'b000100;  4: op_v = 6'b000101;  5: op_v = 6'b001000;
      6: op_v = 6'b001001;  7: op_v = 6'b000010;  8: op_v = 6'b000011;
      default: op_v = 6'b111111;
    endcase
    funct_v = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
    c = mk(0); c.mr = 1'b1; c.asb = 2'b01;
    d = c; d.irw = 1'b1; d.pce = 1'b1;
    plan_wait(c, d, wf, "fetch", tr);
    if (!tr) begin
      c = mk(1); c.asb = 2'b11;
      push(c, rb(), rb(), "decode");
      c = mk(2); c.asa = 1'b1; c.asb = 2'b10;
      case (kind)
        0: begin
          c = mk(6); c.asa = 1'b1; c.aop = 2'b10;
          c.asb = (funct_v == 6'd0) ? 2'b10 : 2'b00;
          push(c, rb(), rb(), "execute");
          c = mk(7); c.rw = 1'b1; c.rd = 1'b1; c.ret = 1'b1;
          push(c, rb(), rb(), "aluwb");
        end
        1: begin
          push(c, rb(), rb(), "memadr");
          c = mk(3); c.mr = 1'b1; c.iord = 1'b1;
          plan_wait(c, c, wm, "memread", tr);
          if (!tr) begin
            c = mk(4); c.rw = 1'b1; c.m2r = 1'b1; c.ret = 1'b1;
            push(c, 1'b1, rb(), "memwb");
          end
        end
        2: begin
          push(c, rb(), rb(), "memadr");
          c = mk(5); c.mw = 1'b1; c.iord = 1'b1;
          d = c; d.ret = 1'b1;
          plan_wait(c, d, wm, "memwrite", tr);
        end
        3, 4: begin
          c = mk(8); c.asa = 1'b1; c.aop = 2'b01; c.pcs = 2'b01; c.ret = 1'b1;
          c.pce = (kind == 3) ? z : !z;
          push(c, rb(), z, "branch");
        end
        5, 6: begin
          c = mk(9); c.asa = 1'b1; c.asb = 2'b10;
          push(c, rb(), rb(), "addiex");
          c = mk(10); c.rw = 1'b1; c.ret = 1'b1;
          push(c, rb(), rb(), "addiwb");
        end
        7: begin
          c = mk(11); c.pce = 1'b1; c.pcs = 2'b10; c.ret = 1'b1;
          push(c, rb(), rb(), "jump");
        end
        8: begin
          c = mk(12); c.pce = 1'b1; c.pcs = 2'b10; c.rw = 1'b1; c.ra = 1'b1;
          c.p2r = 1'b1; c.ret = 1'b1;
          push(c, rb(), rb(), "jal");
        end
        default: begin
          tr = 1'b1;
          push_trap(2'b01, 4);
        end
      endcase
    end
    run_q();
    if (tr) do_reset("trap_reset");
  endtask

  initial begin
    ctl_t c;
    bit tr;
    #2;
    do_reset("init");

    do_instr(1, 0, 0, 1'b0);   // lw zero-wait: states 0,1,2,3,4
    do_instr(3, 0, 0, 1'b1);   // beq taken
    do_instr(4, 0, 0, 1'b1);   // bne not taken
    do_instr(8, 0, 0, 1'b0);   // jal
    do_instr(2, 0, 3, 1'b0);   // sw, three stalls in MEMWRITE
    do_instr(1, 3, 3, 1'b0);   // ready on the last allowed stall cycle
    do_instr(0, 1, 0, 1'b0);

    // lw abandoned mid-MEMREAD
    op_v = 6'b100011; funct_v = 6'd0;
    c = mk(0); c.mr = 1'b1; c.asb = 2'b01; c.irw = 1'b1; c.pce = 1'b1;
    push(c, 1'b1, 1'b0, "fetch");
    c = mk(1); c.asb = 2'b11;
    push(c, 1'b0, 1'b0, "decode");
    c = mk(2); c.asa = 1'b1; c.asb = 2'b10;
    push(c, 1'b0, 1'b0, "memadr");
    c = mk(3); c.mr = 1'b1; c.iord = 1'b1;
    push(c, 1'b0, 1'b0, "memread_wait");
    run_q();
    do_reset("midread_reset");
    do_instr(7, 0, 0, 1'b0);

    do_instr(0, 4, 0, 1'b0);   // FETCH timeout
    do_instr(9, 0, 0, 1'b0);   // illegal opcode
    do_instr(1, 0, 4, 1'b0);   // MEMREAD timeout
    do_instr(2, 2, 4, 1'b0);   // MEMWRITE timeout

    for (int i = 0; i < 40; i++)
      do_instr($urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(0, 3), rb());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
